// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA timing counters: count direction encoding and
// the 640x480@60 horizontal/vertical terminal and sync-window values.
package vga_timing_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam int H_LIMIT      = 799;
  localparam int H_SYNC_START = 656;
  localparam int H_SYNC_END   = 752;

  localparam int V_LIMIT      = 524;
  localparam int V_SYNC_START = 490;
  localparam int V_SYNC_END   = 492;

endpackage

// File: rtl/vga_window_cmp.sv
// Combinational window compare: in_window when value lies in [win_start, win_end),
// wrapping through zero when win_start > win_end, empty when they are equal.
module vga_window_cmp #(
  parameter int WIDTH = 10
) (
  input  logic [WIDTH-1:0] value,
  input  logic [WIDTH-1:0] win_start,
  input  logic [WIDTH-1:0] win_end,
  output logic             in_window
);

  always_comb begin
    in_window = 1'b0;
    if (win_start < win_end) begin
      in_window = (value >= win_start) && (value < win_end);
    end else if (win_start > win_end) begin
      in_window = (value >= win_start) || (value < win_end);
    end
  end

endmodule

// File: rtl/vga_timing_counter.sv
// Programmable up/down VGA timing counter with load, cascadeable terminal count,
// registered wrap pulse and a registered sync window aligned with Q.
module vga_timing_counter
  import vga_timing_pkg::*;
#(
  parameter int WIDTH    = 10,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             Count,
  input  logic             Load,
  input  logic             Dir,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] Limit,
  input  logic [WIDTH-1:0] SyncStart,
  input  logic [WIDTH-1:0] SyncEnd,
  output logic [WIDTH-1:0] Q,
  output logic             Tc,
  output logic             Wrap,
  output logic             Sync
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             sync_q, sync_d;
  logic             at_term;
  logic             in_window;

  // Down-counting terminates at zero; up-counting at or above Limit so a
  // loaded value past Limit still wraps back to zero on the next count.
  assign at_term = (Dir == DIR_DOWN) ? (q_q == '0) : (q_q >= Limit);

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (Load) begin
      q_d = D;
    end else if (Count) begin
      if (at_term) begin
        q_d    = (Dir == DIR_DOWN) ? Limit : '0;
        wrap_d = 1'b1;
      end else begin
        q_d = (Dir == DIR_DOWN) ? q_q - 1'b1 : q_q + 1'b1;
      end
    end
  end

  // Compare against the next-state value so Sync lands in the same cycle as Q.
  vga_window_cmp #(.WIDTH(WIDTH)) u_window_cmp (
    .value     (q_d),
    .win_start (SyncStart),
    .win_end   (SyncEnd),
    .in_window (in_window)
  );

  always_comb begin
    sync_d = in_window ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
      sync_q <= ~SYNC_POL;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
      sync_q <= sync_d;
    end
  end

  assign Q    = q_q;
  assign Tc   = Count & ~Load & at_term;
  assign Wrap = wrap_q;
  assign Sync = sync_q;

endmodule
